ysyx_23060077_mem_arb: RTL and testbench

- Shares the single AXI4 master port between the IFU (instruction fetch, burst reads) and the LSU (single-beat loads/stores).
- Sequences each transaction through address, data and response phases. One transaction is outstanding at a time.
- Returns read beats, completion and error status to the requester that won the grant.
- Sits between ifu/lsu and the io_master_* pins of the top level.

---
 rtl/ysyx_23060077_axi_define.sv | 8 +
 rtl/ysyx_23060077_mem_arb.sv | 147 ++++++++++++++
 tb/tb_ysyx_23060077_mem_arb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_axi_define.sv
// ysyx_23060077_axi_define: shared AXI constants, ids and arbiter state encodings
package ysyx_23060077_axi_define;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] IFU_ID = 4'd0;
  localparam logic [3:0] LSU_ID = 4'd1;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B} arb_state_e;
endpackage

// File: rtl/ysyx_23060077_mem_arb.sv
// ysyx_23060077_mem_arb: shares one AXI4 master between IFU bursts and LSU single beats
module ysyx_23060077_mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter logic [3:0] IFU_ID = ysyx_23060077_axi_define::IFU_ID,
  parameter logic [3:0] LSU_ID = ysyx_23060077_axi_define::LSU_ID
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_valid,
  input  logic [ADDR_W-1:0] ifu_addr,
  input  logic [7:0]        ifu_len,
  output logic              ifu_ready,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rlast,
  output logic              ifu_err,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [2:0]        lsu_size,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awid,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [7:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  input  logic [3:0]        m_bid,
  output logic              m_bready,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [3:0]        m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [3:0]        m_rid,
  output logic              m_rready
);
  import ysyx_23060077_axi_define::*;
  arb_state_e state, state_n;
  logic deny_ifu, gnt_ifu_q, aw_done, w_done, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] len_q, wstrb_q;
  logic [2:0] size_q;
  logic [3:0] id_q;
  logic [DATA_W-1:0] wdata_q;
  logic gnt_ifu, gnt_lsu, aw_fire, w_fire, err_all, r_ifu, r_lsu, b_fire;
  // reset gates the grants so no ready can pulse while reset is held
  assign gnt_ifu = reset && state == S_IDLE && ifu_valid && (!lsu_valid || deny_ifu);
  assign gnt_lsu = reset && state == S_IDLE && lsu_valid && !(ifu_valid && deny_ifu);
  assign aw_fire = m_awvalid && m_awready;
  assign w_fire  = m_wvalid && m_wready;
  assign b_fire  = state == S_B && m_bvalid;
  assign err_all = err_q || m_rresp != AXI_RESP_OKAY || m_rid != id_q;
  assign r_ifu   = state == S_R && gnt_ifu_q && m_rvalid;
  assign r_lsu   = state == S_R && !gnt_ifu_q && m_rvalid;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = gnt_ifu ? S_AR : gnt_lsu ? (lsu_we ? S_WR : S_AR) : S_IDLE;
      S_AR:    state_n = m_arready ? S_R : S_AR;
      S_R:     state_n = (m_rvalid && m_rlast) ? S_IDLE : S_R;
      S_WR:    state_n = ((aw_done || aw_fire) && (w_done || w_fire)) ? S_B : S_WR;
      S_B:     state_n = m_bvalid ? S_IDLE : S_B;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? state_n : S_IDLE;
  always_ff @(posedge clock) begin
    if (!reset) begin
      deny_ifu  <= 1'b0;
      gnt_ifu_q <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      id_q      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (gnt_ifu || gnt_lsu) begin
        deny_ifu  <= gnt_ifu ? 1'b0 : (deny_ifu || ifu_valid);
        gnt_ifu_q <= gnt_ifu;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        err_q     <= 1'b0;
        addr_q    <= gnt_ifu ? ifu_addr : lsu_addr;
        len_q     <= gnt_ifu ? ifu_len : 8'd0;
        size_q    <= gnt_ifu ? 3'b010 : lsu_size;
        id_q      <= gnt_ifu ? IFU_ID : LSU_ID;
        wdata_q   <= lsu_wdata;
        wstrb_q   <= lsu_wstrb;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire) w_done <= 1'b1;
      if (state == S_R && m_rvalid) err_q <= err_all;
    end
  end
  assign ifu_ready  = gnt_ifu;
  assign lsu_ready  = gnt_lsu;
  assign ifu_rvalid = r_ifu;
  assign ifu_rdata  = r_ifu ? m_rdata : '0;
  assign ifu_rlast  = r_ifu && m_rlast;
  assign ifu_err    = r_ifu && m_rlast && err_all;
  assign lsu_done   = r_lsu || b_fire;
  assign lsu_rdata  = r_lsu ? m_rdata : '0;
  assign lsu_err    = r_lsu ? err_all : (b_fire && (m_bresp != AXI_RESP_OKAY || m_bid != LSU_ID));
  assign m_arvalid  = state == S_AR;
  assign m_araddr   = addr_q;
  assign m_arid     = id_q;
  assign m_arlen    = len_q;
  assign m_arsize   = size_q;
  assign m_arburst  = m_arvalid ? AXI_BURST_INCR : 2'b00;
  assign m_rready   = state == S_R;
  assign m_awvalid  = state == S_WR && !aw_done;
  assign m_awaddr   = addr_q;
  assign m_awid     = id_q;
  assign m_awlen    = len_q;
  assign m_awsize   = size_q;
  assign m_awburst  = m_awvalid ? AXI_BURST_INCR : 2'b00;
  assign m_wvalid   = state == S_WR && !w_done;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;
  assign m_wlast    = m_wvalid;
  assign m_bready   = state == S_B;
endmodule

// File: tb/tb_ysyx_23060077_mem_arb.sv
// tb_ysyx_23060077_mem_arb: directed checks of arbitration, read/write sequencing and reset
module tb_ysyx_23060077_mem_arb;
  logic clock = 1'b0, reset = 1'b0;
  logic ifu_valid = 0, ifu_ready, ifu_rvalid, ifu_rlast, ifu_err;
  logic [31:0] ifu_addr = 0;
  logic [7:0] ifu_len = 0;
  logic [63:0] ifu_rdata;
  logic lsu_valid = 0, lsu_we = 0, lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_addr = 0;
  logic [2:0] lsu_size = 0;
  logic [63:0] lsu_wdata = 0, lsu_rdata;
  logic [7:0] lsu_wstrb = 0;
  logic m_awvalid, m_awready = 0, m_wvalid, m_wlast, m_wready = 0;
  logic [31:0] m_awaddr, m_araddr;
  logic [3:0] m_awid, m_arid, m_bid = 0, m_rid = 0;
  logic [7:0] m_awlen, m_arlen, m_wstrb;
  logic [2:0] m_awsize, m_arsize;
  logic [1:0] m_awburst, m_arburst, m_bresp = 0, m_rresp = 0;
  logic [63:0] m_wdata, m_rdata = 0;
  logic m_bvalid = 0, m_bready, m_arvalid, m_arready = 0, m_rvalid = 0, m_rlast = 0, m_rready;
  int total = 0, passed = 0;

  ysyx_23060077_mem_arb dut (
    .clock(clock), .reset(reset),
    .ifu_valid(ifu_valid), .ifu_addr(ifu_addr), .ifu_len(ifu_len), .ifu_ready(ifu_ready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rlast(ifu_rlast), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_ready(lsu_ready), .lsu_done(lsu_done),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rready(m_rready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ar_accept(input int hold);
    for (int i = 0; i < hold; i++) begin
      #1 chk("arvalid_wait", m_arvalid, 1'b1);
      tick();
    end
    m_arready = 1;
    #1 chk("arvalid_hs", m_arvalid, 1'b1);
    tick();
    m_arready = 0;
  endtask

  // read beats: rid/rresp of beat bad_beat are replaced by bad_id/bad_resp
  task automatic rbeats(input int n, input logic [3:0] id, input int bad_beat,
                        input logic [3:0] bad_id, input logic [1:0] bad_resp,
                        input logic ifu_side, input logic exp_err);
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1;
      m_rdata = 64'hA5A5_0000_0000_0000 + 64'(i);
      m_rlast = (i == n - 1);
      m_rid = (i == bad_beat) ? bad_id : id;
      m_rresp = (i == bad_beat) ? bad_resp : 2'b00;
      #1;
      chk("rready", m_rready, 1'b1);
      chk("no_grant_in_r", {ifu_ready, lsu_ready}, 2'b00);
      if (ifu_side) begin
        chk("ifu_rvalid", ifu_rvalid, 1'b1);
        chk("ifu_rdata", ifu_rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
        chk("ifu_rlast", ifu_rlast, (i == n - 1));
        chk("ifu_err", ifu_err, (i == n - 1) && exp_err);
      end else begin
        chk("lsu_done", lsu_done, 1'b1);
        chk("lsu_rdata", lsu_rdata, 64'hA5A5_0000_0000_0000 + 64'(i));
        chk("lsu_err", lsu_err, exp_err);
      end
      tick();
    end
    m_rvalid = 0;
    m_rlast = 0;
    m_rid = 0;
    m_rresp = 0;
  endtask

  initial begin
    // reset state with requests pending
    ifu_valid = 1;
    tick();
    tick();
    chk("rst_ready", {ifu_ready, lsu_ready}, 2'b00);
    chk("rst_master", {m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready, m_arburst, m_awburst}, 9'd0);
    chk("rst_ret", {ifu_rvalid, ifu_err, lsu_done, lsu_err}, 4'd0);
    ifu_valid = 0;
    reset = 1;
    tick();
    // IFU alone, arready delayed two cycles
    ifu_valid = 1; ifu_addr = 32'h3000_0000; ifu_len = 8'd3;
    #1 chk("ifu_ready", ifu_ready, 1'b1);
    tick();
    ifu_valid = 0;
    chk("arvalid_lat", m_arvalid, 1'b1);
    chk("araddr", m_araddr, 32'h3000_0000);
    chk("arlen", m_arlen, 8'd3);
    chk("arsize", m_arsize, 3'd2);
    chk("arid", m_arid, 4'd0);
    chk("arburst", m_arburst, 2'b01);
    chk("ready_pulse", ifu_ready, 1'b0);
    ar_accept(2);
    chk("arvalid_drop", m_arvalid, 1'b0);
    rbeats(4, 4'd0, -1, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("idle_rready", m_rready, 1'b0);
    // contested grants alternate LSU, IFU, LSU
    ifu_valid = 1; ifu_addr = 32'h3000_0100; ifu_len = 8'd1;
    lsu_valid = 1; lsu_we = 0; lsu_addr = 32'h8000_0010; lsu_size = 3'd2;
    #1 chk("c1_grant", {ifu_ready, lsu_ready}, 2'b01);
    tick();
    chk("c1_arid", m_arid, 4'd1);
    chk("c1_arlen", m_arlen, 8'd0);
    chk("c1_araddr", m_araddr, 32'h8000_0010);
    ar_accept(0);
    rbeats(1, 4'd1, -1, 4'd0, 2'b00, 1'b0, 1'b0);
    chk("c2_grant", {ifu_ready, lsu_ready}, 2'b10);
    tick();
    chk("c2_arid", m_arid, 4'd0);
    chk("c2_arlen", m_arlen, 8'd1);
    ar_accept(0);
    rbeats(2, 4'd0, -1, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("c3_grant", {ifu_ready, lsu_ready}, 2'b01);
    tick();
    ifu_valid = 0; lsu_valid = 0;
    chk("c3_arid", m_arid, 4'd1);
    ar_accept(0);
    rbeats(1, 4'd1, -1, 4'd0, 2'b00, 1'b0, 1'b0);
    // LSU store, W before AW
    lsu_valid = 1; lsu_we = 1; lsu_addr = 32'h8000_0004; lsu_size = 3'd2;
    lsu_wdata = 64'h1122_3344_0000_0000; lsu_wstrb = 8'hF0;
    #1 chk("st_ready", lsu_ready, 1'b1);
    tick();
    lsu_valid = 0; lsu_we = 0;
    chk("st_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
    chk("st_awaddr", m_awaddr, 32'h8000_0004);
    chk("st_aw", {m_awid, m_awlen, m_awsize, m_awburst}, {4'd1, 8'd0, 3'd2, 2'b01});
    chk("st_w", {m_wdata, m_wstrb, 7'd0, m_wlast}, {64'h1122_3344_0000_0000, 8'hF0, 8'h01});
    m_wready = 1;
    tick();
    m_wready = 0;
    chk("st_wdrop", {m_awvalid, m_wvalid, m_bready}, 3'b100);
    m_awready = 1;
    tick();
    m_awready = 0;
    chk("st_b", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    m_bvalid = 1; m_bresp = 2'b00; m_bid = 4'd1;
    #1 chk("st_done", {lsu_done, lsu_err}, 2'b10);
    tick();
    m_bvalid = 0;
    chk("st_idle", {lsu_done, m_bready}, 2'b00);
    // LSU load with SLVERR, then next request right after
    lsu_valid = 1; lsu_addr = 32'h8000_0020; lsu_size = 3'd0;
    #1 chk("ld_ready", lsu_ready, 1'b1);
    tick();
    chk("ld_arsize", m_arsize, 3'd0);
    ar_accept(0);
    rbeats(1, 4'd1, 0, 4'd1, 2'b10, 1'b0, 1'b1);
    chk("ld_next_ready", lsu_ready, 1'b1);
    tick();
    lsu_valid = 0;
    ar_accept(0);
    rbeats(1, 4'd1, -1, 4'd0, 2'b00, 1'b0, 1'b0);
    // IFU burst with wrong rid mid-burst: error only on last beat
    ifu_valid = 1; ifu_addr = 32'h3000_0200; ifu_len = 8'd7;
    tick();
    ifu_valid = 0;
    chk("eb_arlen", m_arlen, 8'd7);
    ar_accept(0);
    rbeats(8, 4'd0, 3, 4'd1, 2'b00, 1'b1, 1'b1);
    // reset mid-burst
    ifu_valid = 1; ifu_addr = 32'h3000_0300; ifu_len = 8'd3;
    tick();
    ifu_valid = 0;
    ar_accept(0);
    m_rvalid = 1; m_rdata = 64'h1; m_rid = 0;
    #1 chk("mid_rvalid", ifu_rvalid, 1'b1);
    tick();
    ifu_valid = 1; ifu_addr = 32'h3000_0400; ifu_len = 8'd3;
    reset = 0;
    tick();
    #1;
    chk("mr_outs", {ifu_rvalid, ifu_ready, lsu_ready, m_rready, m_arvalid, m_awvalid, m_wvalid, m_bready}, 8'd0);
    m_rvalid = 0;
    reset = 1;
    #1 chk("mr_regrant", ifu_ready, 1'b1);
    tick();
    ifu_valid = 0;
    chk("mr_araddr", m_araddr, 32'h3000_0400);
    ar_accept(0);
    rbeats(4, 4'd0, -1, 4'd0, 2'b00, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
